btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 3: number of button channels (bit 0 = left, bit 1 = right, bit 2 = start/restart).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: number of consecutive stable clk cycles needed to accept a new level (10 ms at 100 MHz).
REQ-003 Parameter REPEAT_DELAY, default 30000000; parameter REPEAT_PERIOD, default 10000000. Both are used only when the repeat feature is compiled in.
REQ-004 Port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port btn_raw, input, N_BTN bits: raw, asynchronous, bouncing button/JA pins; 1 = pressed.
REQ-007 Port btn_level, output, N_BTN bits: debounced level.
REQ-008 Port btn_press, output, N_BTN bits: one-cycle pulse on an accepted 0->1 transition.
REQ-009 Port btn_release, output, N_BTN bits: one-cycle pulse on an accepted 1->0 transition.
REQ-010 Port btn_repeat, output, N_BTN bits: auto-repeat pulses; exists only with the macro in REQ-025.

Function
REQ-011 Each btn_raw bit SHALL pass through a two-flop synchronizer; no other logic SHALL observe btn_raw directly.
REQ-012 Each channel SHALL hold a stable bit and a counter sized $clog2(DEBOUNCE_CYCLES+1).
REQ-013 Counter behaviour:
- clear to 0 in any cycle where the synchronized bit equals the stable bit;
- otherwise increment by 1.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and the synchronized bit still differs:
- the stable bit SHALL toggle on that edge;
- the counter SHALL clear.
REQ-015 btn_level SHALL equal the stable bits. Total latency from a clean btn_raw edge to btn_level change is 2+DEBOUNCE_CYCLES cycles.
REQ-016 btn_press / btn_release SHALL assert in exactly the cycle btn_level changes, for exactly one cycle, and never both for one channel in the same cycle.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse; every reversal restarts the count from 0.
REQ-018 Channels are independent. Simultaneous transitions on several channels SHALL produce simultaneous pulses.
REQ-019 DEBOUNCE_CYCLES=1 SHALL be legal: the level follows the synchronizer output with one cycle of delay.

Reset
REQ-020 While reset=0, the following SHALL be 0 asynchronously:
- synchronizer flops, stable bits, counters;
- btn_level, btn_press, btn_release, btn_repeat.
REQ-021 Release of reset SHALL be synchronized internally (assert async, deassert sync). In the first cycle after release, no pulse SHALL occur even if btn_raw is held high; a held button is then accepted as a normal press after 2+DEBOUNCE_CYCLES cycles.
REQ-022 Reset asserted mid-count SHALL discard the partial count.

Configuration
REQ-023 The repeat feature SHALL be controlled by the macro BTN_CONDITIONER_REPEAT_EN.
REQ-024 Macro defined: per channel, a repeat timer starts at btn_press.
- btn_repeat pulses once REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles while btn_level=1.
- btn_repeat does not pulse in the same cycle as btn_press.
- The timer clears on release or reset.
REQ-025 Macro undefined: the btn_repeat port, the REPEAT_* logic and the timers SHALL NOT exist; parameters REPEAT_DELAY/REPEAT_PERIOD remain but are unused.

Structure
REQ-026 Shared package goose_input_pkg SHALL hold:
- default DEBOUNCE/REPEAT constants;
- channel index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_START=2.
REQ-027 One sub-module btn_debounce_ch SHALL implement a single channel (synchronizer, counter, stable bit, edge pulses, optional repeat timer). btn_conditioner SHALL instantiate it N_BTN times via generate.
REQ-028 The block sits directly upstream of the game top level and replaces its direct JA/reset sampling:
- btn_press[BTN_START] drives menu/restart transitions;
- btn_level[BTN_LEFT/RIGHT] drives goose movement.

Verification
REQ-029 The bench SHALL run with DEBOUNCE_CYCLES=8, N_BTN=3 and cover:
- Reset held low with btn_raw=3'b111 -> all outputs 0. After release with btn_raw still high -> btn_press=3'b111 exactly 10 cycles after the first post-reset edge, 1 cycle wide.
- btn_raw[0] 0->1 clean -> btn_level[0] rises 10 cycles later; btn_press[0] is a single 1-cycle pulse; btn_release stays 0.
- btn_raw[1] toggling every 3 cycles for 40 cycles -> btn_level[1] stays 0, no pulses; counter never exceeds 3.
- btn_raw[0] and btn_raw[2] rise in the same cycle -> btn_press=3'b101 in one cycle. Later, release -> btn_release=3'b101 in one cycle.
- Reset pulsed low at counter=5 during a press -> outputs 0 immediately; the press is re-accepted 10 cycles after reset release.
- BTN_CONDITIONER_REPEAT_EN defined, REPEAT_DELAY=20, REPEAT_PERIOD=5, button held 40 cycles -> btn_repeat pulses at press+20, +25, +30, +35; stops on release.

Source files
------------

// File: rtl/goose_input_pkg.sv
// Shared constants for the goose game input path: default timing values,
// button channel indices and a small sizing helper.
package goose_input_pkg;

   localparam int DEFAULT_N_BTN           = 3;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;   // 10 ms at 100 MHz
   localparam int DEFAULT_REPEAT_DELAY    = 30000000;  // 300 ms at 100 MHz
   localparam int DEFAULT_REPEAT_PERIOD   = 10000000;  // 100 ms at 100 MHz

   // Channel indices into the button vectors
   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_START = 2;

   // Larger of two integers, used to size shared timers
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the game logic.
// btn_repeat only exists when BTN_CONDITIONER_REPEAT_EN is defined.
interface btn_conditioner_if
   import goose_input_pkg::*;
#(
   parameter int N_BTN = DEFAULT_N_BTN
);

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
`ifdef BTN_CONDITIONER_REPEAT_EN
   logic [N_BTN-1:0] btn_repeat;
`endif

   // Pin side: drives the raw buttons, consumes the conditioned events
   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release
`ifdef BTN_CONDITIONER_REPEAT_EN
      , input btn_repeat
`endif
   );

   // Conditioner side: samples the raw buttons, produces the events
   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release
`ifdef BTN_CONDITIONER_REPEAT_EN
      , output btn_repeat
`endif
   );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter, debounced
// level with press/release pulses, and (with BTN_CONDITIONER_REPEAT_EN)
// an auto-repeat timer.
module btn_debounce_ch
   import goose_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
)(
   input  logic clk,
   input  logic reset,       // raw active-low reset, clears the synchronizer
   input  logic core_reset,  // active-low reset with synchronous release
   input  logic raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
`ifdef BTN_CONDITIONER_REPEAT_EN
   , output logic repeat_pulse
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta_reg;
   logic          sync_reg;
   logic [CW-1:0] count_reg;
   logic          stable_reg;
   logic          press_reg;
   logic          release_reg;
   logic          differ;
   logic          accept;

   // The synchronizer runs from the raw reset so it starts sampling on the
   // first edge after release, keeping post-reset latency equal to the
   // normal press latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta_reg <= 1'b0;
         sync_reg      <= 1'b0;
      end else begin
         sync_meta_reg <= raw;
         sync_reg      <= sync_meta_reg;
      end
   end

   assign differ = sync_reg ^ stable_reg;
   assign accept = differ && (count_reg == COUNT_LAST);

   // Count consecutive cycles of disagreement; any agreement restarts from 0
   always_ff @(posedge clk or negedge core_reset) begin
      if (!core_reset) begin
         count_reg <= '0;
      end else if (!differ || accept) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Accept the new level and emit the matching edge pulse on the same edge
   always_ff @(posedge clk or negedge core_reset) begin
      if (!core_reset) begin
         stable_reg  <= 1'b0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
      end else begin
         if (accept) begin
            stable_reg <= ~stable_reg;
         end
         press_reg   <= accept & ~stable_reg;
         release_reg <= accept &  stable_reg;
      end
   end

   assign level         = stable_reg;
   assign press_pulse   = press_reg;
   assign release_pulse = release_reg;

`ifdef BTN_CONDITIONER_REPEAT_EN
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [RW-1:0] rpt_cnt_reg;
   logic          rpt_reg;

   // Down-counter loaded at the press, reloaded with the period at each
   // repeat, held at 0 whenever the button is released or releasing.
   always_ff @(posedge clk or negedge core_reset) begin
      if (!core_reset) begin
         rpt_cnt_reg <= '0;
         rpt_reg     <= 1'b0;
      end else begin
         rpt_reg <= 1'b0;
         if (accept && !stable_reg) begin
            rpt_cnt_reg <= RW'(REPEAT_DELAY - 1);
         end else if (stable_reg && !accept) begin
            if (rpt_cnt_reg == '0) begin
               rpt_reg     <= 1'b1;
               rpt_cnt_reg <= RW'(REPEAT_PERIOD - 1);
            end else begin
               rpt_cnt_reg <= rpt_cnt_reg - 1'b1;
            end
         end else begin
            rpt_cnt_reg <= '0;
         end
      end
   end

   assign repeat_pulse = rpt_reg;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner for the goose game: synchronizes, debounces and
// edge-detects N_BTN raw buttons. Define BTN_CONDITIONER_REPEAT_EN to add
// auto-repeat pulses on btn_repeat.
module btn_conditioner
   import goose_input_pkg::*;
#(
   parameter int N_BTN           = DEFAULT_N_BTN,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
)(
   input  logic               clk,
   input  logic               reset,
   btn_conditioner_if.slave   bus
);

   logic rst_meta_reg;
   logic core_reset_reg;

   // Reset bridge: assertion is immediate, release is aligned to clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta_reg   <= 1'b0;
         core_reset_reg <= 1'b0;
      end else begin
         rst_meta_reg   <= 1'b1;
         core_reset_reg <= rst_meta_reg;
      end
   end

   for (genvar gi = 0; gi < N_BTN; gi++) begin : gen_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .core_reset    (core_reset_reg),
         .raw           (bus.btn_raw[gi]),
         .level         (bus.btn_level[gi]),
         .press_pulse   (bus.btn_press[gi]),
         .release_pulse (bus.btn_release[gi])
`ifdef BTN_CONDITIONER_REPEAT_EN
         , .repeat_pulse (bus.btn_repeat[gi])
`endif
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=8, N_BTN=3.
// Repeat scenario runs only when BTN_CONDITIONER_REPEAT_EN is defined.
module tb_btn_conditioner;
   import goose_input_pkg::*;

   localparam int N  = 3;
   localparam int D  = 8;
   localparam int RD = 20;
   localparam int RP = 5;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   btn_conditioner_if #(.N_BTN(N)) bus ();

   btn_conditioner #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [N-1:0] exp_lvl, exp_prs, exp_rel;
      reset = 1'b0;
      bus.btn_raw = 3'b111;
      repeat (3) step();
      n_cmp++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got lvl=%b prs=%b rel=%b expected all 0",
                  bus.btn_level, bus.btn_press, bus.btn_release);
      end
      reset = 1'b1;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_prs = (s == 10) ? 3'b111 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b111 : 3'b000;
         n_cmp++;
         if (bus.btn_press !== exp_prs || bus.btn_level !== exp_lvl || bus.btn_release !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=000",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_prs);
         end
      end
      bus.btn_raw = 3'b000;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_rel = (s == 10) ? 3'b111 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b000 : 3'b111;
         n_cmp++;
         if (bus.btn_release !== exp_rel || bus.btn_level !== exp_lvl || bus.btn_press !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_all_release step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=000 rel=%b",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_rel);
         end
      end
   endtask

   task automatic test_single_press();
      logic [N-1:0] exp_lvl, exp_prs, exp_rel;
      bus.btn_raw = 3'b001;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_prs = (s == 10) ? 3'b001 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b001 : 3'b000;
         n_cmp++;
         if (bus.btn_press !== exp_prs || bus.btn_level !== exp_lvl || bus.btn_release !== 3'b000) begin
            n_bad++;
            $display("FAIL single_press step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=000",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_prs);
         end
      end
      bus.btn_raw = 3'b000;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_rel = (s == 10) ? 3'b001 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b000 : 3'b001;
         n_cmp++;
         if (bus.btn_release !== exp_rel || bus.btn_level !== exp_lvl || bus.btn_press !== 3'b000) begin
            n_bad++;
            $display("FAIL single_release step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=000 rel=%b",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_rel);
         end
      end
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 40; i++) begin
         bus.btn_raw = (((i / 3) % 2) == 0) ? 3'b010 : 3'b000;
         step();
         n_cmp++;
         if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.btn_release !== 3'b000) begin
            n_bad++;
            $display("FAIL glitch_outputs cycle %0d: got lvl=%b prs=%b rel=%b expected all 000",
                     i, bus.btn_level, bus.btn_press, bus.btn_release);
         end
         n_cmp++;
         if (dut.gen_ch[1].u_ch.count_reg > 4'd3) begin
            n_bad++;
            $display("FAIL glitch_count cycle %0d: got count=%0d expected <= 3",
                     i, dut.gen_ch[1].u_ch.count_reg);
         end
      end
      bus.btn_raw = 3'b000;
      repeat (4) begin
         step();
         n_cmp++;
         if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000) begin
            n_bad++;
            $display("FAIL glitch_settle: got lvl=%b prs=%b expected 000 000",
                     bus.btn_level, bus.btn_press);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] exp_lvl, exp_prs, exp_rel;
      bus.btn_raw = 3'b101;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_prs = (s == 10) ? 3'b101 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b101 : 3'b000;
         n_cmp++;
         if (bus.btn_press !== exp_prs || bus.btn_level !== exp_lvl || bus.btn_release !== 3'b000) begin
            n_bad++;
            $display("FAIL simul_press step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=000",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_prs);
         end
      end
      bus.btn_raw = 3'b000;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_rel = (s == 10) ? 3'b101 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b000 : 3'b101;
         n_cmp++;
         if (bus.btn_release !== exp_rel || bus.btn_level !== exp_lvl || bus.btn_press !== 3'b000) begin
            n_bad++;
            $display("FAIL simul_release step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=000 rel=%b",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_rel);
         end
      end
   endtask

   task automatic test_reset_mid_count();
      logic [N-1:0] exp_lvl, exp_prs;
      bus.btn_raw = 3'b100;
      repeat (10) step();
      n_cmp++;
      if (bus.btn_level !== 3'b100) begin
         n_bad++;
         $display("FAIL midrst_setup: got lvl=%b expected 100", bus.btn_level);
      end
      bus.btn_raw = 3'b101;
      repeat (7) step();
      n_cmp++;
      if (dut.gen_ch[0].u_ch.count_reg !== 4'd5) begin
         n_bad++;
         $display("FAIL midrst_count: got count=%0d expected 5", dut.gen_ch[0].u_ch.count_reg);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.btn_level, bus.btn_press, bus.btn_release} !== 9'b0) begin
         n_bad++;
         $display("FAIL midrst_async: got lvl=%b prs=%b rel=%b expected all 0",
                  bus.btn_level, bus.btn_press, bus.btn_release);
      end
      repeat (2) begin
         step();
         n_cmp++;
         if ({bus.btn_level, bus.btn_press, bus.btn_release} !== 9'b0) begin
            n_bad++;
            $display("FAIL midrst_held: got lvl=%b prs=%b rel=%b expected all 0",
                     bus.btn_level, bus.btn_press, bus.btn_release);
         end
      end
      reset = 1'b1;
      for (int s = 1; s <= 12; s++) begin
         step();
         exp_prs = (s == 10) ? 3'b101 : 3'b000;
         exp_lvl = (s >= 10) ? 3'b101 : 3'b000;
         n_cmp++;
         if (bus.btn_press !== exp_prs || bus.btn_level !== exp_lvl || bus.btn_release !== 3'b000) begin
            n_bad++;
            $display("FAIL midrst_reaccept step %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=000",
                     s, bus.btn_level, bus.btn_press, bus.btn_release, exp_lvl, exp_prs);
         end
      end
      bus.btn_raw = 3'b000;
      repeat (12) step();
      n_cmp++;
      if (bus.btn_level !== 3'b000) begin
         n_bad++;
         $display("FAIL midrst_cleanup: got lvl=%b expected 000", bus.btn_level);
      end
   endtask

`ifdef BTN_CONDITIONER_REPEAT_EN
   task automatic test_repeat();
      logic [N-1:0] exp_rpt, exp_prs, exp_rel;
      bus.btn_raw = 3'b001;
      for (int s = 1; s <= 56; s++) begin
         step();
         exp_rpt = (s == 30 || s == 35 || s == 40 || s == 45) ? 3'b001 : 3'b000;
         exp_prs = (s == 10) ? 3'b001 : 3'b000;
         exp_rel = (s == 50) ? 3'b001 : 3'b000;
         n_cmp++;
         if (bus.btn_repeat !== exp_rpt || bus.btn_press !== exp_prs || bus.btn_release !== exp_rel) begin
            n_bad++;
            $display("FAIL repeat step %0d: got rpt=%b prs=%b rel=%b expected rpt=%b prs=%b rel=%b",
                     s, bus.btn_repeat, bus.btn_press, bus.btn_release, exp_rpt, exp_prs, exp_rel);
         end
         if (s == 40) bus.btn_raw = 3'b000;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_reset_mid_count();
`ifdef BTN_CONDITIONER_REPEAT_EN
      test_repeat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
